// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the active-low hex decode table.
// Segment bit order is a,b,c,d,e,f,g from bit6 down to bit0.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n occupies bits [7*n +: 7]; F sits in the top slice, 0 in the bottom.
    localparam logic [16*7-1:0] SEG_TABLE = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

    function automatic logic [6:0] hex_a_seg(input logic [3:0] hex);
        return SEG_TABLE[7*hex +: 7];
    endfunction

endpackage

// File: rtl/seg7_hex_deco.sv
// Combinational hex-to-segment decoder for the digit currently being scanned.
module seg7_hex_deco
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_a_seg(hex);

endmodule

// File: rtl/display7seg_mux.sv
// Time-multiplexed N-digit 7-segment driver with per-digit enable, decimal point,
// blink, leading-zero suppression and a blanking dead time at the start of each slot.
module display7seg_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 8,
    parameter int BLINK_SLOTS  = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] valor,
    input  logic                    cargar,
    input  logic [NUM_DIGITS-1:0]   habilitar,
    input  logic [NUM_DIGITS-1:0]   punto,
    input  logic [NUM_DIGITS-1:0]   parpadeo,
    input  logic                    suprimir_ceros,
    output logic [6:0]              segmentos,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anodos,
    output logic                    frame_fin
);

    localparam int SLOT_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRAME_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

    logic [4*NUM_DIGITS-1:0] valor_q, valor_d;
    logic [NUM_DIGITS-1:0]   habilitar_q, habilitar_d;
    logic [NUM_DIGITS-1:0]   punto_q, punto_d;
    logic [NUM_DIGITS-1:0]   parpadeo_q, parpadeo_d;

    logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]   digit_idx_q, digit_idx_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               blink_phase_q, blink_phase_d;

    logic [6:0]            segmentos_q, segmentos_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] anodos_q, anodos_d;
    logic                  frame_fin_q, frame_fin_d;

    logic                  slot_wrap, idx_wrap, frame_end, frame_wrap;
    logic                  in_blank, zero_run;
    logic [NUM_DIGITS-1:0] suprimido;
    logic [3:0]            cur_nibble;
    logic                  cur_visible, cur_punto;
    logic [6:0]            cur_seg;

    always_comb begin
        valor_d     = valor_q;
        habilitar_d = habilitar_q;
        punto_d     = punto_q;
        parpadeo_d  = parpadeo_q;
        if (cargar) begin
            valor_d     = valor;
            habilitar_d = habilitar;
            punto_d     = punto;
            parpadeo_d  = parpadeo;
        end
    end

    always_comb begin
        slot_wrap  = (slot_cnt_q == SLOT_W'(REFRESH_DIV - 1));
        idx_wrap   = (digit_idx_q == IDX_W'(NUM_DIGITS - 1));
        frame_end  = slot_wrap & idx_wrap;
        frame_wrap = (frame_cnt_q == FRAME_W'(BLINK_SLOTS - 1));

        slot_cnt_d    = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        digit_idx_d   = digit_idx_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (slot_wrap) begin
            digit_idx_d = idx_wrap ? '0 : digit_idx_q + 1'b1;
        end
        if (frame_end) begin
            if (frame_wrap) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Disabled digits count as zero when scanning down for leading zeros.
    always_comb begin
        zero_run  = 1'b1;
        suprimido = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run & (~habilitar_q[k] | (valor_q[4*k +: 4] == 4'h0));
            suprimido[k] = suprimir_ceros & zero_run & (k != 0);
        end
    end

    always_comb begin
        cur_nibble  = 4'h0;
        cur_visible = 1'b0;
        cur_punto   = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx_q == IDX_W'(k)) begin
                cur_nibble  = valor_q[4*k +: 4];
                cur_visible = habilitar_q[k] & ~(parpadeo_q[k] & blink_phase_q) & ~suprimido[k];
                cur_punto   = punto_q[k];
            end
        end
    end

    seg7_hex_deco u_deco (
        .hex (cur_nibble),
        .seg (cur_seg)
    );

    always_comb begin
        in_blank    = (int'(slot_cnt_q) < BLANK_CYCLES);
        anodos_d    = '1;
        segmentos_d = SEG_BLANK;
        dp_d        = 1'b1;
        frame_fin_d = frame_end;
        if (!in_blank && cur_visible) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                anodos_d[k] = (digit_idx_q != IDX_W'(k));
            end
            segmentos_d = cur_seg;
            dp_d        = ~cur_punto;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valor_q       <= '0;
            habilitar_q   <= '0;
            punto_q       <= '0;
            parpadeo_q    <= '0;
            slot_cnt_q    <= '0;
            digit_idx_q   <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            segmentos_q   <= SEG_BLANK;
            dp_q          <= 1'b1;
            anodos_q      <= '1;
            frame_fin_q   <= 1'b0;
        end else begin
            valor_q       <= valor_d;
            habilitar_q   <= habilitar_d;
            punto_q       <= punto_d;
            parpadeo_q    <= parpadeo_d;
            slot_cnt_q    <= slot_cnt_d;
            digit_idx_q   <= digit_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            segmentos_q   <= segmentos_d;
            dp_q          <= dp_d;
            anodos_q      <= anodos_d;
            frame_fin_q   <= frame_fin_d;
        end
    end

    assign segmentos = segmentos_q;
    assign dp        = dp_q;
    assign anodos    = anodos_q;
    assign frame_fin = frame_fin_q;

endmodule

// File: tb/tb_display7seg_mux.sv
// Randomized scoreboard bench for display7seg_mux using a cycle-count based reference model.
module tb_display7seg_mux;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BL = 1;
    localparam int BS = 2;

    typedef struct packed {
        logic [ND-1:0] an;
        logic [6:0]    seg;
        logic          dp;
        logic          ff;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [4*ND-1:0] valor = '0;
    logic            cargar = 1'b0;
    logic [ND-1:0]   habilitar = '0;
    logic [ND-1:0]   punto = '0;
    logic [ND-1:0]   parpadeo = '0;
    logic            suprimir_ceros = 1'b0;
    logic [6:0]      segmentos;
    logic            dp;
    logic [ND-1:0]   anodos;
    logic            frame_fin;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];

    logic [6:0] seg_tbl [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    display7seg_mux #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BL),
        .BLINK_SLOTS  (BS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valor          (valor),
        .cargar         (cargar),
        .habilitar      (habilitar),
        .punto          (punto),
        .parpadeo       (parpadeo),
        .suprimir_ceros (suprimir_ceros),
        .segmentos      (segmentos),
        .dp             (dp),
        .anodos         (anodos),
        .frame_fin      (frame_fin)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: everything is derived from the number of cycles since reset.
    initial begin
        int t;
        int pos, slot, d, frame;
        bit phase, vis, zr;
        exp_t e;
        logic [4*ND-1:0] sh_val;
        logic [ND-1:0]   sh_hab, sh_pt, sh_blk;
        t = 0;
        sh_val = '0; sh_hab = '0; sh_pt = '0; sh_blk = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                t = 0;
                sh_val = '0; sh_hab = '0; sh_pt = '0; sh_blk = '0;
                exp_q.delete();
            end else begin
                pos   = t % RD;
                slot  = t / RD;
                d     = slot % ND;
                frame = slot / ND;
                phase = ((frame / BS) % 2) == 1;
                e.an  = '1;
                e.seg = 7'h7F;
                e.dp  = 1'b1;
                e.ff  = (pos == RD - 1) && (d == ND - 1);
                if (pos >= BL) begin
                    zr = 1'b1;
                    for (int k = ND - 1; k >= d; k--) begin
                        if (sh_hab[k] && sh_val[4*k +: 4] != 4'h0) zr = 1'b0;
                    end
                    vis = sh_hab[d] && !(sh_blk[d] && phase) && !(suprimir_ceros && d > 0 && zr);
                    if (vis) begin
                        e.an[d] = 1'b0;
                        e.seg   = seg_tbl[sh_val[4*d +: 4]];
                        e.dp    = !sh_pt[d];
                    end
                end
                exp_q.push_back(e);
                if (cargar) begin
                    sh_val = valor; sh_hab = habilitar; sh_pt = punto; sh_blk = parpadeo;
                end
                t++;
            end
        end
    end

    // Monitor: the DUT presents a new output every cycle while out of reset.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("anodos", 32'(anodos), 32'(e.an));
            checkOutput("segmentos", 32'(segmentos), 32'(e.seg));
            checkOutput("dp", 32'(dp), 32'(e.dp));
            checkOutput("frame_fin", 32'(frame_fin), 32'(e.ff));
        end
    end

    task automatic stepCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Drive a set of inputs, strobe cargar for load_len cycles, then let the scan run.
    task automatic applyStimulus(input logic [4*ND-1:0] v, input logic [ND-1:0] hab,
                                 input logic [ND-1:0] pt, input logic [ND-1:0] blk,
                                 input logic sup, input int load_len, input int run_len);
        valor = v; habilitar = hab; punto = pt; parpadeo = blk; suprimir_ceros = sup;
        cargar = (load_len > 0);
        stepCycles((load_len > 0) ? load_len : 1);
        cargar = 1'b0;
        stepCycles(run_len);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stepCycles(3);
        rst_n = 1'b1;
        stepCycles(2);

        applyStimulus(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0, 1, 40);
        applyStimulus(16'h9876, 4'hF, 4'h0, 4'h0, 1'b0, 0, 20);
        applyStimulus(16'hABCD, 4'hF, 4'h0, 4'h0, 1'b0, 1, 20);
        applyStimulus(16'h0050, 4'hF, 4'h0, 4'h0, 1'b1, 1, 20);
        applyStimulus(16'h0050, 4'hF, 4'h0, 4'h0, 1'b0, 0, 20);
        applyStimulus(16'h0000, 4'hF, 4'h0, 4'h0, 1'b1, 1, 20);
        applyStimulus(16'h5678, 4'hF, 4'b0010, 4'b0001, 1'b0, 1, 100);
        applyStimulus(16'h1357, 4'b0101, 4'hF, 4'h0, 1'b0, 1, 48);
        applyStimulus(16'h00F0, 4'b1011, 4'h0, 4'h0, 1'b1, 3, 20);

        stepCycles(2);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_anodos", 32'(anodos), 32'h0000000F);
        checkOutput("reset_segmentos", 32'(segmentos), 32'h0000007F);
        checkOutput("reset_dp", 32'(dp), 32'h1);
        checkOutput("reset_frame_fin", 32'(frame_fin), 32'h0);
        stepCycles(2);
        rst_n = 1'b1;
        stepCycles(1);

        applyStimulus(16'hC0DE, 4'hF, 4'b0101, 4'b1000, 1'b1, 1, 36);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                          1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 40)));
            if ($urandom_range(0, 3) == 0) begin
                suprimir_ceros = ~suprimir_ceros;
                stepCycles(int'($urandom_range(1, 20)));
            end
        end

        checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
